pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset (RstEnable = 1).
REQ-003 SHALL have port stallreq_from_if  in  1  instruction-bus wait request.
REQ-004 SHALL have port stallreq_from_id  in  1  load-use hazard request.
REQ-005 SHALL have port stallreq_from_ex  in  1  multi-cycle ALU request (madd/msub/div).
REQ-006 SHALL have port stallreq_from_mem  in  1  data-bus wait request.
REQ-007 SHALL have port ibus_busy_i  in  1  instruction-bus transaction outstanding.
REQ-008 SHALL have port excepttype_i  in  32  final exception type from MEM stage; 0 = none.
REQ-009 SHALL have port cp0_epc_i  in  32  current EPC for eret.
REQ-010 SHALL have port stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-011 SHALL have port flush  out  1  one-cycle flush of all pipeline registers.
REQ-012 SHALL have port new_pc  out  32  PC redirect target, valid only while flush = 1.
REQ-013 SHALL have ports stall_cycles_o  out  32  and flush_count_o  out  16  (see Configuration).

Function
REQ-014 SHALL implement states RUN, WAIT_BUS, FLUSH.
REQ-015 In RUN with excepttype_i = 0, stall SHALL be combinational by priority: mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else if -> 6'b000011; else 6'b000000.
REQ-016 In RUN with excepttype_i != 0 and ibus_busy_i = 0, flush SHALL be 1 combinationally in that cycle, stall 6'b000000, state stays RUN.
REQ-017 new_pc SHALL be cp0_epc_i when excepttype = 32'h0000000e (eret), else EXC_VECTOR (32'h00000020).
REQ-018 In RUN with excepttype_i != 0 and ibus_busy_i = 1, block SHALL latch the new_pc value, keep flush = 0, drive stall 6'b111111 and enter WAIT_BUS next cycle.
REQ-019 In WAIT_BUS stall SHALL be 6'b111111 and flush 0; when ibus_busy_i = 0 sampled, next state SHALL be FLUSH.
REQ-020 In FLUSH, flush SHALL be 1, new_pc the latched value, stall 6'b000000, for exactly one cycle, then RUN.
REQ-021 excepttype_i and stallreq_* inputs SHALL be ignored in WAIT_BUS and FLUSH.
REQ-022 Whenever flush = 0, new_pc SHALL be 32'h0.
REQ-023 Flush SHALL take priority over every stall request in the same cycle.

Reset
REQ-024 On rst = 1 at a clock edge, state SHALL become RUN, latched PC 0, counters 0.
REQ-025 While rst = 1, outputs SHALL be stall 6'b000000, flush 0, new_pc 0 regardless of other inputs; reset mid-WAIT_BUS discards the pending redirect.

Configuration
REQ-026 Macro PIPE_CTRL_PERF_EN defined: stall_cycles_o SHALL count cycles with stall != 0, flush_count_o cycles with flush = 1; both saturate at all-ones, no wrap.
REQ-027 Macro PIPE_CTRL_PERF_EN undefined: no counter registers; stall_cycles_o and flush_count_o tied to 0.

Structure
REQ-028 Shared package SHALL hold stall-vector constants (STALL_NONE/IF/ID/EX/MEM/ALL), EXC_VECTOR, EXC_ERET code and the state enum.
REQ-029 One sub-module sat_counter (parameter WIDTH, inc, clear) SHALL implement both perf counters; instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-030 stallreq_from_id = 1 and stallreq_from_mem = 1 same cycle -> stall = 6'b011111, flush 0.
REQ-031 excepttype_i = 32'h00000008, ibus_busy_i = 0 -> same cycle flush 1, new_pc 32'h00000020, stall 0; next cycle flush 0.
REQ-032 excepttype_i = 32'h0000000e, cp0_epc_i = 32'h00400010, ibus_busy_i = 1 for 3 cycles -> stall 6'b111111 for 4 cycles, then one cycle flush 1, new_pc 32'h00400010.
REQ-033 rst = 1 asserted while in WAIT_BUS -> next cycle RUN, no flush ever issued for the discarded exception.
REQ-034 PIPE_CTRL_PERF_EN defined, 10 stalled cycles then 2 flushes -> stall_cycles_o = 10, flush_count_o = 2; counter forced to 16'hFFFF stays 16'hFFFF after further flush.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline controller: stall-vector encodings,
//   the exception redirect constants, the controller state enum and a helper
//   that selects the redirect target for a given exception type.
//   Stall vector bit order: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
//   bit4 MEM/WB, bit5 WB; a 1 holds that stage.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
    localparam logic [31:0] EXC_ERET   = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_BUS = 2'd1,
        ST_FLUSH    = 2'd2
    } pipe_state_e;

    // eret returns to EPC; every other exception enters the common vector.
    function automatic logic [31:0] redirect_pc(input logic [31:0] excepttype,
                                                input logic [31:0] epc);
        return (excepttype == EXC_ERET) ? epc : EXC_VECTOR;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter: increments on inc, holds at all-ones, returns to
//   zero on a synchronous clear (clear wins over inc).
//   Ports:
//     clk    in  1      clock
//     clear  in  1      synchronous clear
//     inc    in  1      count this cycle
//     count  out WIDTH  current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline stall/flush controller. In normal running the stall vector is a
//   priority decode of the per-stage stall requests. An exception from MEM
//   flushes the whole pipeline and redirects the PC; if an instruction-bus
//   transaction is still outstanding the redirect is parked (full stall)
//   until the bus goes idle, then issued as a one-cycle flush.
//
//   Bus wait protocol: ibus_busy_i high means the instruction bus still owns
//   an in-flight transaction; a redirect may only be issued in a cycle where
//   ibus_busy_i is sampled low.
//
//   Optional feature macro: PIPE_CTRL_PERF_EN
//     defined   -> saturating counters of stalled cycles and flush cycles
//     undefined -> no counter state, counter outputs tied to 0
//
//   Ports:
//     clk               in  1   clock, rising edge
//     rst               in  1   synchronous active-high reset
//     stallreq_from_if  in  1   instruction-bus wait request
//     stallreq_from_id  in  1   load-use hazard request
//     stallreq_from_ex  in  1   multi-cycle ALU request
//     stallreq_from_mem in  1   data-bus wait request
//     ibus_busy_i       in  1   instruction-bus transaction outstanding
//     excepttype_i      in  32  exception type from MEM, 0 = none
//     cp0_epc_i         in  32  EPC used by eret
//     stall             out 6   per-stage hold vector
//     flush             out 1   one-cycle flush of all pipeline registers
//     new_pc            out 32  redirect target, 0 whenever flush = 0
//     stall_cycles_o    out 32  cycles with stall != 0 (perf build)
//     flush_count_o     out 16  cycles with flush = 1 (perf build)
//     dbg_state         out 2   current controller state
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        ibus_busy_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o,
    output pipe_state_e dbg_state
);

    pipe_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = 32'h0;

        // Reset forces quiet outputs combinationally, so nothing leaks out
        // of the pipeline during the reset cycle itself.
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (excepttype_i != 32'h0) begin
                        if (!ibus_busy_i) begin
                            // Flush outranks every stall request.
                            flush  = 1'b1;
                            new_pc = redirect_pc(excepttype_i, cp0_epc_i);
                        end else begin
                            // Park the target; the exception inputs may change
                            // while we wait for the bus.
                            stall   = STALL_ALL;
                            pc_d    = redirect_pc(excepttype_i, cp0_epc_i);
                            state_d = ST_WAIT_BUS;
                        end
                    end else if (stallreq_from_mem) begin
                        stall = STALL_MEM;
                    end else if (stallreq_from_ex) begin
                        stall = STALL_EX;
                    end else if (stallreq_from_id) begin
                        stall = STALL_ID;
                    end else if (stallreq_from_if) begin
                        stall = STALL_IF;
                    end
                end
                ST_WAIT_BUS: begin
                    stall = STALL_ALL;
                    if (!ibus_busy_i) begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    flush   = 1'b1;
                    new_pc  = pc_q;
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall != STALL_NONE),
        .count (stall_cycles_o)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (flush),
        .count (flush_count_o)
    );
`else
    assign stall_cycles_o = 32'h0;
    assign flush_count_o  = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
    logic        ibus_busy_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;
    pipe_state_e dbg_state;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .ibus_busy_i       (ibus_busy_i),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cycles_o    (stall_cycles_o),
        .flush_count_o     (flush_count_o),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [38:0] exp_q[$];
    string       tag_q[$];
    int          tests_run  = 0;
    int          fail_count = 0;
    logic [31:0] exp_stall_cnt = 32'h0;
    logic [15:0] exp_flush_cnt = 16'h0;

    // Independent reference for the run-state priority decode.
    function automatic logic [5:0] prio_stall(input logic [3:0] req);
        // req = {mem, ex, id, if}
        if (req[3]) return 6'b011111;
        if (req[2]) return 6'b001111;
        if (req[1]) return 6'b000111;
        if (req[0]) return 6'b000011;
        return 6'b000000;
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge: drives one cycle of inputs, queues the
    // expected outputs, compares on the falling edge, then advances a cycle.
    task automatic step(input logic r, input logic [3:0] req, input logic busy,
                        input logic [31:0] exc, input logic [31:0] epc,
                        input logic [5:0] e_stall, input logic e_flush,
                        input logic [31:0] e_pc, input string tag);
        logic [38:0] got, exp;
        string       t;
        rst               = r;
        stallreq_from_mem = req[3];
        stallreq_from_ex  = req[2];
        stallreq_from_id  = req[1];
        stallreq_from_if  = req[0];
        ibus_busy_i       = busy;
        excepttype_i      = exc;
        cp0_epc_i         = epc;
        exp_q.push_back({e_stall, e_flush, e_pc});
        tag_q.push_back(tag);
        @(negedge clk);
        got = {stall, flush, new_pc};
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        tests_run++;
        assert (got === exp) else begin
            fail_count++;
            $error("FAIL %s: observed stall=%b flush=%b new_pc=%h, expected stall=%b flush=%b new_pc=%h",
                   t, got[38:33], got[32], got[31:0], exp[38:33], exp[32], exp[31:0]);
        end
        // Counter model: what the upcoming edge should add.
        if (r) begin
            exp_stall_cnt = 32'h0;
            exp_flush_cnt = 16'h0;
        end else begin
            if (e_stall != 6'b0 && exp_stall_cnt != 32'hFFFF_FFFF) exp_stall_cnt++;
            if (e_flush && exp_flush_cnt != 16'hFFFF) exp_flush_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input pipe_state_e e, input string tag);
        tests_run++;
        assert (dbg_state === e) else begin
            fail_count++;
            $error("FAIL %s: observed state=%0d, expected state=%0d", tag, dbg_state, e);
        end
    endtask

    task automatic check_counters(input string tag);
        logic [31:0] e_s;
        logic [15:0] e_f;
`ifdef PIPE_CTRL_PERF_EN
        e_s = exp_stall_cnt;
        e_f = exp_flush_cnt;
`else
        e_s = 32'h0;
        e_f = 16'h0;
`endif
        tests_run++;
        assert (stall_cycles_o === e_s && flush_count_o === e_f) else begin
            fail_count++;
            $error("FAIL %s: observed stall_cycles=%0d flush_count=%0d, expected stall_cycles=%0d flush_count=%0d",
                   tag, stall_cycles_o, flush_count_o, e_s, e_f);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] req;
        rst = 1'b1;
        stallreq_from_if = 1'b0; stallreq_from_id = 1'b0;
        stallreq_from_ex = 1'b0; stallreq_from_mem = 1'b0;
        ibus_busy_i = 1'b0; excepttype_i = 32'h0; cp0_epc_i = 32'h0;
        @(posedge clk);
        #1;

        // Reset: outputs quiet regardless of requests/exceptions.
        step(1, 4'b1111, 0, 32'h8, 32'h1234, STALL_NONE, 0, 32'h0, "reset_exc");
        step(1, 4'b1000, 1, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "reset_req");
        check_state(ST_RUN, "reset_state");
        check_counters("reset_counters");

        // Stall priority decode.
        step(0, 4'b0000, 0, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "idle");
        step(0, 4'b0001, 0, 32'h0, 32'h0, STALL_IF,   0, 32'h0, "stall_if");
        step(0, 4'b0010, 0, 32'h0, 32'h0, STALL_ID,   0, 32'h0, "stall_id");
        step(0, 4'b0100, 0, 32'h0, 32'h0, STALL_EX,   0, 32'h0, "stall_ex");
        step(0, 4'b1000, 0, 32'h0, 32'h0, STALL_MEM,  0, 32'h0, "stall_mem");
        step(0, 4'b1010, 0, 32'h0, 32'h0, STALL_MEM,  0, 32'h0, "id_and_mem");
        step(0, 4'b0111, 1, 32'h0, 32'h0, STALL_EX,   0, 32'h0, "ex_id_if");

        // Immediate exception flush, outranks stall requests.
        step(0, 4'b1111, 0, 32'h8, 32'h00400010, STALL_NONE, 1, 32'h20, "exc_flush");
        step(0, 4'b0000, 0, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "after_flush");
        step(0, 4'b0000, 0, 32'he, 32'h00400010, STALL_NONE, 1, 32'h00400010, "eret_flush");

        // eret with bus busy for 3 cycles: 4 full-stall cycles then flush.
        step(0, 4'b0000, 1, 32'he, 32'h00400010, STALL_ALL, 0, 32'h0, "wait0");
        check_state(ST_WAIT_BUS, "wait_entered");
        step(0, 4'b1000, 1, 32'h8, 32'h0BADF00D, STALL_ALL, 0, 32'h0, "wait1");
        step(0, 4'b0001, 1, 32'h0, 32'h0, STALL_ALL, 0, 32'h0, "wait2");
        step(0, 4'b0100, 0, 32'h8, 32'h0, STALL_ALL, 0, 32'h0, "wait3");
        step(0, 4'b1000, 0, 32'h8, 32'hFFFF0000, STALL_NONE, 1, 32'h00400010, "late_flush");
        step(0, 4'b0000, 0, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "after_late_flush");

        // Reset during WAIT_BUS drops the parked redirect.
        step(0, 4'b0000, 1, 32'h8, 32'h0, STALL_ALL, 0, 32'h0, "rwait0");
        step(0, 4'b0000, 1, 32'h0, 32'h0, STALL_ALL, 0, 32'h0, "rwait1");
        step(1, 4'b0000, 0, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "rwait_reset");
        check_state(ST_RUN, "rwait_state");
        for (int i = 0; i < 3; i++)
            step(0, 4'b0000, 0, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "no_stale_flush");

        // Randomised request mix in RUN.
        for (int i = 0; i < 20; i++) begin
            req = 4'($urandom_range(0, 15));
            step(0, req, 1'($urandom_range(0, 1)), 32'h0, $urandom, prio_stall(req), 0, 32'h0, "rand_stall");
        end
        check_counters("counters_mix");

        // 10 stalled cycles then 2 flushes from a clean count.
        step(1, 4'b0000, 0, 32'h0, 32'h0, STALL_NONE, 0, 32'h0, "perf_reset");
        for (int i = 0; i < 10; i++)
            step(0, 4'b0001, 0, 32'h0, 32'h0, STALL_IF, 0, 32'h0, "perf_stall");
        step(0, 4'b0000, 0, 32'h4, 32'h0, STALL_NONE, 1, 32'h20, "perf_flush0");
        step(0, 4'b0000, 0, 32'h4, 32'h0, STALL_NONE, 1, 32'h20, "perf_flush1");
        check_counters("perf_10_2");

`ifdef PIPE_CTRL_PERF_EN
        force dut.u_flush_cnt.count_q = 16'hFFFF;
        #1;
        release dut.u_flush_cnt.count_q;
        exp_flush_cnt = 16'hFFFF;
        step(0, 4'b0000, 0, 32'h4, 32'h0, STALL_NONE, 1, 32'h20, "sat_flush");
        check_counters("flush_saturate");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
